// File: rtl/fb_scanout_arbiter.sv
// Single-port framebuffer arbiter: prefetches scanout pixels into a show-ahead FIFO
// and hands spare memory cycles to a writer whenever the FIFO has enough slack.
module fb_scanout_arbiter #(
    parameter int pixel_bits_p   = 8,
    parameter int addr_bits_p    = 19,
    parameter int frame_pixels_p = 307200,
    parameter int fifo_depth_p   = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         frame_start_i,
    input  logic                         pix_ready_i,
    output logic                         pix_valid_o,
    output logic [2:0][pixel_bits_p-1:0] pix_data_o,
    output logic                         underflow_o,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [addr_bits_p-1:0]       wr_addr_i,
    input  logic [2:0][pixel_bits_p-1:0] wr_data_i,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [addr_bits_p-1:0]       mem_addr_o,
    output logic [2:0][pixel_bits_p-1:0] mem_wdata_o,
    input  logic [2:0][pixel_bits_p-1:0] mem_rdata_i
);
    localparam int ptr_bits_lp = $clog2(fifo_depth_p);
    localparam int cnt_bits_lp = ptr_bits_lp + 1;
    localparam logic [cnt_bits_lp-1:0] depth_lp     = cnt_bits_lp'(fifo_depth_p);
    localparam logic [cnt_bits_lp-1:0] half_lp      = cnt_bits_lp'(fifo_depth_p / 2);
    localparam logic [addr_bits_p-1:0] last_addr_lp = addr_bits_p'(frame_pixels_p - 1);

    typedef logic [2:0][pixel_bits_p-1:0] pixel_t;

    logic [addr_bits_p-1:0] fetch_addr;
    logic                   fetch_active;
    logic                   inflight;
    logic [cnt_bits_lp-1:0] count;
    logic [ptr_bits_lp-1:0] rd_ptr;
    logic [ptr_bits_lp-1:0] wr_ptr;
    pixel_t                 fifo_mem [fifo_depth_p];

    logic [cnt_bits_lp-1:0] level;
    logic                   read_needed;
    logic                   read_urgent;
    logic                   grant_read;
    logic                   grant_write;
    logic                   push;
    logic                   pop;

    // An in-flight read already owns a FIFO slot, so it counts toward the fill level.
    always_comb begin
        level       = count + cnt_bits_lp'(inflight);
        read_needed = fetch_active && (level < depth_lp) && !frame_start_i;
        read_urgent = read_needed && (level < half_lp);
        grant_write = wr_valid_i && !read_urgent && !reset_i;
        grant_read  = read_needed && !grant_write;
    end

    assign wr_ready_o  = grant_write;
    assign mem_en_o    = grant_write || grant_read;
    assign mem_we_o    = grant_write;
    assign mem_addr_o  = grant_write ? wr_addr_i : fetch_addr;
    assign mem_wdata_o = grant_write ? wr_data_i : '0;

    assign pix_valid_o = (count != '0);
    assign pix_data_o  = pix_valid_o ? fifo_mem[rd_ptr] : '0;

    // A frame start flushes the FIFO, so a return landing that cycle is dropped.
    assign push = inflight && !frame_start_i;
    assign pop  = pix_ready_i && pix_valid_o && !frame_start_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_addr   <= '0;
            fetch_active <= 1'b0;
            inflight     <= 1'b0;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            underflow_o  <= 1'b0;
        end else begin
            inflight <= grant_read;
            if (pix_ready_i && !pix_valid_o) begin
                underflow_o <= 1'b1;
            end
            if (frame_start_i) begin
                fetch_addr   <= '0;
                fetch_active <= 1'b1;
                count        <= '0;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
            end else begin
                if (grant_read) begin
                    fetch_addr <= fetch_addr + addr_bits_p'(1);
                    if (fetch_addr == last_addr_lp) begin
                        fetch_active <= 1'b0;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + ptr_bits_lp'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_bits_lp'(1);
                end
                if (push && !pop) begin
                    count <= count + cnt_bits_lp'(1);
                end else if (pop && !push) begin
                    count <= count - cnt_bits_lp'(1);
                end
            end
        end
    end

    // NOTE: FIFO storage has no reset; count gates every read of it, so stale
    // contents never reach the outputs.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata_i;
        end
    end

    count_bound_a: assert property (@(posedge clk_i) disable iff (reset_i) count <= depth_lp);

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Self-checking bench for fb_scanout_arbiter: queue-based scanout model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fb_scanout_arbiter;
    localparam int frame_lp = 40;
    localparam int depth_lp = 8;

    logic             clk_i;
    logic             reset_i;
    logic             frame_start_i;
    logic             pix_ready_i;
    logic             pix_valid_o;
    logic [2:0][7:0]  pix_data_o;
    logic             underflow_o;
    logic             wr_valid_i;
    logic             wr_ready_o;
    logic [18:0]      wr_addr_i;
    logic [2:0][7:0]  wr_data_i;
    logic             mem_en_o;
    logic             mem_we_o;
    logic [18:0]      mem_addr_o;
    logic [2:0][7:0]  mem_wdata_o;
    logic [2:0][7:0]  mem_rdata_i;

    fb_scanout_arbiter #(
        .pixel_bits_p  (8),
        .addr_bits_p   (19),
        .frame_pixels_p(frame_lp),
        .fifo_depth_p  (depth_lp)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .frame_start_i(frame_start_i),
        .pix_ready_i  (pix_ready_i),
        .pix_valid_o  (pix_valid_o),
        .pix_data_o   (pix_data_o),
        .underflow_o  (underflow_o),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory content seen by the reader: each word holds its own address.
    function automatic logic [23:0] pix_of(input int a);
        return 24'(a);
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    // ---------------- behavioural model ----------------
    int   m_q[$];
    bit   m_pend;
    int   m_pend_addr;
    int   m_next;
    bit   m_fetch_on;
    bit   m_under;
    int   m_level;
    bit   m_need;
    bit   m_urgent;
    bit   m_read;
    bit   m_write;
    bit   dut_rd;
    logic [18:0] dut_rd_addr;
    int   last_rd_addr;

    always @(negedge clk_i) begin
        if (reset_i) begin
            m_q.delete();
            m_pend     = 1'b0;
            m_next     = 0;
            m_fetch_on = 1'b0;
            m_under    = 1'b0;
            dut_rd     = 1'b0;
            check("cmp_rst_mem_en", mem_en_o, 0);
            check("cmp_rst_wr_ready", wr_ready_o, 0);
            check("cmp_rst_pix_valid", pix_valid_o, 0);
            check("cmp_rst_pix_data", pix_data_o, 0);
            check("cmp_rst_underflow", underflow_o, 0);
        end else begin
            m_level  = m_q.size() + (m_pend ? 1 : 0);
            m_need   = m_fetch_on && (m_level < depth_lp) && !frame_start_i;
            m_urgent = m_need && (m_level < depth_lp / 2);
            m_write  = wr_valid_i && !m_urgent;
            m_read   = !m_write && m_need;

            check("cmp_mem_en", mem_en_o, m_read || m_write);
            check("cmp_mem_we", mem_we_o, m_write);
            check("cmp_wr_ready", wr_ready_o, m_write);
            if (m_read) check("cmp_rd_addr", mem_addr_o, m_next);
            if (m_write) begin
                check("cmp_wr_addr", mem_addr_o, wr_addr_i);
                check("cmp_wr_data", mem_wdata_o, wr_data_i);
            end
            check("cmp_pix_valid", pix_valid_o, m_q.size() != 0);
            check("cmp_pix_data", pix_data_o, (m_q.size() != 0) ? pix_of(m_q[0]) : 24'h0);
            check("cmp_underflow", underflow_o, m_under);

            if (pix_ready_i && m_q.size() == 0) m_under = 1'b1;
            if (frame_start_i) begin
                m_q.delete();
                m_next     = 0;
                m_fetch_on = 1'b1;
            end else begin
                if (pix_ready_i && m_q.size() != 0) void'(m_q.pop_front());
                if (m_pend) m_q.push_back(m_pend_addr);
            end
            m_pend = m_read;
            if (m_read) begin
                m_pend_addr = m_next;
                if (m_next == frame_lp - 1) m_fetch_on = 1'b0;
                m_next++;
            end

            dut_rd      = mem_en_o && !mem_we_o;
            dut_rd_addr = mem_addr_o;
            if (dut_rd) last_rd_addr = int'(mem_addr_o);
        end
    end

    // Single-port memory: read data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk_i) begin
        #1;
        mem_rdata_i = dut_rd ? pix_of(int'(dut_rd_addr)) : 24'ha5a5a5;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int popped;
        reset_i       = 1'b1;
        frame_start_i = 1'b0;
        pix_ready_i   = 1'b0;
        wr_valid_i    = 1'b1;
        wr_addr_i     = '0;
        wr_data_i     = '0;
        mem_rdata_i   = '0;
        last_rd_addr  = -1;

        // Reset holds every output low, even with a writer requesting.
        repeat (2) sample();
        check("rst_mem_en", mem_en_o, 0);
        check("rst_wr_ready", wr_ready_o, 0);
        check("rst_pix_valid", pix_valid_o, 0);
        check("rst_underflow", underflow_o, 0);

        // Writes are granted immediately after reset, and nothing is read.
        step();
        reset_i   = 1'b0;
        wr_addr_i = 19'd5;
        wr_data_i = 24'h010203;
        sample();
        check("wr_ready", wr_ready_o, 1);
        check("wr_we", mem_we_o, 1);
        check("wr_en", mem_en_o, 1);
        check("wr_addr5", mem_addr_o, 5);
        check("wr_data", mem_wdata_o, 24'h010203);
        for (int k = 1; k < 4; k++) begin
            step();
            wr_addr_i = 19'(100 + k);
            wr_data_i = 24'(k * 3);
            sample();
            check("wr_only_we", mem_we_o, 1);
            check("wr_only_addr", mem_addr_o, 100 + k);
        end
        step();
        wr_valid_i = 1'b0;
        sample();
        check("idle_en", mem_en_o, 0);
        check("idle_wr_ready", wr_ready_o, 0);

        // Frame start: reads 0..7 back to back, then stop with the FIFO full.
        step();
        frame_start_i = 1'b1;
        sample();
        check("fs_no_read", mem_en_o, 0);
        step();
        frame_start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sample();
            check("fill_rd", mem_en_o && !mem_we_o, 1);
            check("fill_addr", mem_addr_o, k);
            if (k == 1) check("lat_not_yet", pix_valid_o, 0);
            if (k == 2) begin
                check("lat_valid", pix_valid_o, 1);
                check("lat_data", pix_data_o, 0);
            end
            step();
        end
        sample();
        check("fill_stop", mem_en_o, 0);
        step();
        sample();
        check("full_no_read", mem_en_o, 0);
        check("full_head_valid", pix_valid_o, 1);
        check("full_head_data", pix_data_o, 0);

        // Writer contention while consuming every cycle: writes until level drops below half.
        step();
        wr_valid_i  = 1'b1;
        pix_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_addr_i = 19'(200 + k);
            wr_data_i = 24'(k);
            sample();
            if (k < 5) begin
                check("cont_write", wr_ready_o, 1);
                check("cont_waddr", mem_addr_o, 200 + k);
            end else begin
                check("cont_read_wins", wr_ready_o, 0);
                check("cont_read", mem_en_o && !mem_we_o, 1);
            end
            step();
        end
        wr_valid_i    = 1'b0;
        pix_ready_i   = 1'b0;
        frame_start_i = 1'b1;
        sample();
        check("cont_no_underflow", underflow_o, 0);
        check("resync_no_read", mem_en_o, 0);

        // Full frame drain at half rate after a mid-fetch restart.
        step();
        frame_start_i = 1'b0;
        popped = 0;
        for (int cyc = 0; cyc < 8 * frame_lp && popped < frame_lp; cyc++) begin
            pix_ready_i = (cyc >= 4) && cyc[0];
            sample();
            if (pix_ready_i && pix_valid_o) begin
                check("drain_order", pix_data_o, pix_of(popped));
                popped++;
            end
            step();
        end
        pix_ready_i = 1'b0;
        check("drain_count", popped, frame_lp);
        repeat (4) begin
            step();
            sample();
            check("end_no_read", mem_en_o, 0);
        end
        check("last_read_addr", last_rd_addr, frame_lp - 1);
        check("drain_no_underflow", underflow_o, 0);

        // Consuming from an empty FIFO: zero data, sticky underflow.
        step();
        pix_ready_i = 1'b1;
        sample();
        check("uf_data", pix_data_o, 0);
        check("uf_valid", pix_valid_o, 0);
        check("uf_not_yet", underflow_o, 0);
        step();
        pix_ready_i = 1'b0;
        sample();
        check("uf_set", underflow_o, 1);
        repeat (100) step();
        sample();
        check("uf_held", underflow_o, 1);

        // Asynchronous reset clears the sticky flag without a clock edge.
        step();
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_async_uf", underflow_o, 0);
        step();
        reset_i = 1'b0;
        sample();
        check("post_rst_no_read", mem_en_o, 0);

        // Frame start landing on a read return: return dropped, restart at address 0.
        step();
        frame_start_i = 1'b1;
        sample();
        step();
        frame_start_i = 1'b0;
        sample();
        check("rs_first_addr", mem_addr_o, 0);
        check("rs_first_rd", mem_en_o && !mem_we_o, 1);
        step();
        frame_start_i = 1'b1;
        sample();
        check("rs_fs_no_read", mem_en_o, 0);
        step();
        frame_start_i = 1'b0;
        sample();
        check("rs_discarded", pix_valid_o, 0);
        check("rs_restart_rd", mem_en_o && !mem_we_o, 1);
        check("rs_restart_addr", mem_addr_o, 0);

        // Mid-frame reset with a write granted: outputs drop before any edge.
        repeat (12) step();
        wr_valid_i = 1'b1;
        wr_addr_i  = 19'd7;
        #1;
        check("pre_rst_wr_ready", wr_ready_o, 1);
        check("pre_rst_valid", pix_valid_o, 1);
        #1;
        reset_i = 1'b1;
        #1;
        check("async_mem_en", mem_en_o, 0);
        check("async_mem_we", mem_we_o, 0);
        check("async_wr_ready", wr_ready_o, 0);
        check("async_pix_valid", pix_valid_o, 0);
        check("async_pix_data", pix_data_o, 0);
        check("async_underflow", underflow_o, 0);
        step();
        reset_i    = 1'b0;
        wr_valid_i = 1'b0;
        repeat (5) begin
            sample();
            check("post_rst_idle", mem_en_o, 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fb_scanout_arbiter.md
FB_SCANOUT_ARBITER -- requirements
Module: fb_scanout_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- pixel_bits_p, 8, bits per colour channel.
- addr_bits_p, 19, framebuffer word address width.
- frame_pixels_p, 307200, pixels per frame (640x480).
- fifo_depth_p, 8, prefetch FIFO entries; power of two, at least 4.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, sole clock; all state changes on its rising edge.
- reset_i, in, 1, asynchronous active-high reset.
- frame_start_i, in, 1, one-cycle pulse at start of vertical blank.
- pix_ready_i, in, 1, display timing consumes one pixel this cycle.
- pix_valid_o, out, 1, FIFO head valid.
- pix_data_o, out, [2:0][pixel_bits_p-1:0], FIFO head (show-ahead).
- underflow_o, out, 1, sticky: pixel consumed while FIFO empty.
- wr_valid_i, in, 1, writer request.
- wr_ready_o, out, 1, writer granted this cycle.
- wr_addr_i, in, addr_bits_p, writer address.
- wr_data_i, in, [2:0][pixel_bits_p-1:0], writer pixel.
- mem_en_o, out, 1, single-port memory access strobe.
- mem_we_o, out, 1, write when 1, read when 0.
- mem_addr_o, out, addr_bits_p, memory address.
- mem_wdata_o, out, [2:0][pixel_bits_p-1:0], write data.
- mem_rdata_i, in, [2:0][pixel_bits_p-1:0], read data, valid exactly 1 cycle after a read strobe.

Function
REQ-003 Memory outputs and wr_ready_o shall be combinational from registered state plus current inputs; at most one access per cycle.
REQ-004 Fetch state: fetch_addr (addr_bits_p), fetch_active flag, inflight flag (read issued last cycle), FIFO count (0..fifo_depth_p).
REQ-005 read_needed = fetch_active && (count + inflight < fifo_depth_p) && !frame_start_i.
REQ-006 Arbitration priority:
- (a) read_needed && count + inflight < fifo_depth_p/2 -> read.
- (b) else wr_valid_i -> write.
- (c) else read_needed -> read.
- (d) else idle.
REQ-007 Read grant: mem_en_o=1, mem_we_o=0, mem_addr_o=fetch_addr; next cycle fetch_addr+1 and inflight=1.
REQ-008 When fetch_addr reaches frame_pixels_p-1 and is read, fetch_active shall clear; no read beyond frame_pixels_p-1.
REQ-009 Write grant: wr_ready_o=1, mem_en_o=1, mem_we_o=1, mem_addr_o=wr_addr_i, mem_wdata_o=wr_data_i; transfer occurs on wr_valid_i && wr_ready_o.
REQ-010 wr_ready_o shall be 0 whenever a write is not granted, including idle.
REQ-011 Cycle after a read strobe: mem_rdata_i pushes into FIFO unless frame_start_i occurred in the strobe cycle or the return cycle (then discarded).
REQ-012 Read-to-pixel latency: a read granted at cycle N with an empty FIFO gives pix_valid_o=1 and pix_data_o=data at cycle N+2.
REQ-013 Pop on pix_ready_i && pix_valid_o; simultaneous push and pop leaves count unchanged.
REQ-014 FIFO overflow is impossible by REQ-005 reservation; an assertion shall check count never exceeds fifo_depth_p.
REQ-015 pix_ready_i with FIFO empty:
- pix_data_o=0;
- underflow_o sets the next cycle and stays set until reset.
REQ-016 pix_data_o shall be 0 whenever pix_valid_o=0.
REQ-017 frame_start_i, cycle effects:
- no read issued that cycle;
- FIFO flushed, count=0;
- any pop that cycle ignored;
- fetch_addr=0, fetch_active=1 next cycle;
- writes still arbitrated per REQ-006(b).
REQ-018 frame_start_i during an active fetch shall restart at address 0 (resync); pending return discarded per REQ-011.

Reset
REQ-019 Asserting reset_i shall immediately force the following, independent of clk_i:
- count=0, inflight=0, fetch_active=0, fetch_addr=0;
- underflow_o=0, pix_valid_o=0, pix_data_o=0;
- mem_en_o=0, mem_we_o=0, wr_ready_o=0.
REQ-020 After reset no read shall occur until the first frame_start_i; writes are accepted immediately.

Verification
REQ-021 Reset, then wr_valid_i=1 addr 5 data {1,2,3}, no frame_start -> same cycle wr_ready_o=1, mem_we_o=1, mem_addr_o=5; mem_en_o never reads.
REQ-022 frame_start_i, memory returns addr as data, pix_ready_i=0 -> reads at addresses 0..7 on consecutive cycles, then count=8, mem_en_o=0, pix_data_o=0 at head.
REQ-023 FIFO holding 6 entries, wr_valid_i held high, pix_ready_i=1 each cycle -> write granted while count+inflight>=4, read wins once below 4, no underflow.
REQ-024 Drain full frame with pix_ready_i=1 every other cycle -> 307200 pixels in address order; last read at 307199; fetch_active clears; underflow_o=0.
REQ-025 FIFO empty, pix_ready_i=1 -> pix_data_o=0; underflow_o=1 next cycle and held after 100 more cycles.
REQ-026 frame_start_i in the cycle a read return arrives, plus reset_i asserted mid-frame -> return discarded, count=0, next read address 0; reset clears all outputs without a clock edge.
